// File: rtl/seq_detect_prog.sv
// Run-time programmable serial bit-pattern detector with a bit-valid qualifier,
// overlap/non-overlap modes, a saturating match counter and a config-error flag.
module seq_detect_prog #(
  parameter int unsigned        MAX_LEN = 8,
  parameter int unsigned        LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned        CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] RST_PAT = 'b0000_1011,
  parameter int unsigned        RST_LEN = 4,
  parameter bit                 RST_OVL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_ovl,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pat;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_nxt;
  logic               ovl;
  logic               enough;
  logic               hit;

  assign window = {hist[MAX_LEN-2:0], x};

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(len)) mask[i] = 1'b1;
    end
  end

  // fill >= len-1, evaluated one bit wider so len=0 cannot underflow
  assign enough = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len);

  assign hit = en && !cfg_load && !cfg_err && enough &&
               (((window ^ pat) & mask) == '0);

  always_comb begin
    fill_nxt = fill;
    if (hit && !ovl)                  fill_nxt = '0;
    else if (fill != LEN_W'(MAX_LEN)) fill_nxt = fill + LEN_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat     <= RST_PAT;
      len     <= LEN_W'(RST_LEN);
      ovl     <= RST_OVL;
      hist    <= '0;
      fill    <= '0;
      cfg_err <= 1'b0;
    end else if (cfg_load) begin
      pat     <= cfg_pat;
      len     <= cfg_len;
      ovl     <= cfg_ovl;
      hist    <= '0;
      fill    <= '0;
      cfg_err <= (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
    end else if (en) begin
      hist <= window;
      fill <= fill_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= hit;
      if (cnt_clr)                  match_cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboarded bench: a bit-history reference model predicts match, both
// counters (8-bit and 2-bit instances) and cfg_err; a monitor compares each cycle.
`timescale 1ns/1ps
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst, en, x, cfg_load, cfg_ovl, cnt_clr;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       match8, match2, err8, err2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  seq_detect_prog u8 (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .match(match8), .match_cnt(cnt8), .cfg_err(err8)
  );

  seq_detect_prog #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .cnt_clr(cnt_clr),
    .match(match2), .match_cnt(cnt2), .cfg_err(err2)
  );

  typedef struct {
    bit m;
    int c8;
    int c2;
    bit e;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: the valid bits seen since the last clear, newest last.
  bit   hq[$];
  int   fresh, m_len, c8, c2;
  int   m_pat;
  bit   m_ovl, m_err;

  task automatic tick();
    exp_t e;
    bit   hit;
    int   v;
    hit = 1'b0;
    if (rst) begin
      hq.delete();
      fresh = 0; m_pat = 'h0B; m_len = 4; m_ovl = 1'b1; m_err = 1'b0;
      c8 = 0; c2 = 0;
    end else begin
      if (cfg_load) begin
        m_pat = int'(cfg_pat); m_len = int'(cfg_len); m_ovl = cfg_ovl;
        m_err = (cfg_len == 0) || (cfg_len > 8);
        hq.delete();
        fresh = 0;
      end else if (en) begin
        hq.push_back(x);
        if (hq.size() > 8) void'(hq.pop_front());
        if (fresh < 1000) fresh++;
        if (!m_err && fresh >= m_len) begin
          v = 0;
          for (int i = hq.size() - m_len; i < hq.size(); i++) v = v * 2 + int'(hq[i]);
          hit = (v == (m_pat % (1 << m_len)));
        end
        if (hit && !m_ovl) fresh = 0;
      end
      if (cnt_clr) begin
        c8 = int'(hit); c2 = int'(hit);
      end else if (hit) begin
        if (c8 < 255) c8++;
        if (c2 < 3)   c2++;
      end
    end
    e.m = hit; e.c8 = c8; e.c2 = c2; e.e = m_err;
    sbq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        vectors++;
        if (match8 !== e.m || match2 !== e.m || cnt8 !== 8'(e.c8) ||
            cnt2 !== 2'(e.c2) || err8 !== e.e || err2 !== e.e) begin
          miscompares++;
          $display("FAIL cycle@%0t: match=%b/%b exp %b, cnt=%0d/%0d exp %0d/%0d, err=%b/%b exp %b",
                   $time, match8, match2, e.m, cnt8, cnt2, e.c8, e.c2, err8, err2, e.e);
        end
      end
    end
  end

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      en = 1'b1; x = bits[i];
      tick();
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_load = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o; en = 1'b1; x = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sbq.size());
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; en = 1'b0; x = 1'b0; cfg_load = 1'b0; cfg_pat = '0;
    cfg_len = '0; cfg_ovl = 1'b0; cnt_clr = 1'b0;
    tick();
    rst = 1'b0;

    // Defaults, overlapping: hits after bits 7 and 10
    send(16'b11_0101_1011, 10);
    en = 1'b0; tick();

    // Non-overlapping
    load(8'h0B, 4'd4, 1'b0);
    send(16'b11_0101_1011, 10);

    // 8-bit pattern with en gaps
    load(8'b1010_0110, 4'd8, 1'b1);
    send(16'b1010, 4);
    en = 1'b0; x = 1'b1; tick(); x = 1'b0; tick();
    send(16'b0110, 4);
    en = 1'b0; tick();

    // Invalid lengths, then recovery
    load(8'h0B, 4'd0, 1'b1);
    send(16'b1011_1011, 8);
    load(8'h0B, 4'd9, 1'b1);
    send(16'b1011_1011, 8);
    load(8'h0B, 4'd4, 1'b1);
    send(16'b1011_1011, 8);

    // len=1, counter saturation, clear coincident with a hit
    load(8'h01, 4'd1, 1'b1);
    send(16'b11_1111, 6);
    cnt_clr = 1'b1; send(16'b1, 1); cnt_clr = 1'b0;
    cnt_clr = 1'b1; send(16'b0, 1); cnt_clr = 1'b0;

    // Reset mid-pattern
    load(8'h0B, 4'd4, 1'b1);
    send(16'b101, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    send(16'b1, 1);
    send(16'b1011, 4);

    // Randomised traffic
    for (int n = 0; n < 2000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 3) != 0);
      x        = 1'($urandom);
      cfg_load = ($urandom_range(0, 49) == 0);
      cfg_pat  = 8'($urandom);
      cfg_len  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 4));
      cfg_ovl  = 1'($urandom);
      cnt_clr  = ($urandom_range(0, 29) == 0);
      tick();
    end
    rst = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; en = 1'b0;
    tick();

    @(posedge clk);
    #2;
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, required 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
